// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: parity selection,
// receiver FSM states and the 3-sample majority vote.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-cycle tick every CLK_DIV cycles.
// Never realigned, so it can be shared with a transmitter.
module uart_baud_tick #(
  parameter int CLK_DIV = 26
) (
  input  logic hwclk,
  input  logic resetn,
  output logic tick
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
  end

  always_ff @(posedge hwclk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver with majority vote and valid/ready delivery.
// Define UART_RX_BREAK_DETECT_EN to add break detection and the break_det port.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 26,
  parameter int OVERSAMPLE = 4,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 hwclk,
  input  logic                 resetn,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
`ifdef UART_RX_BREAK_DETECT_EN
  output logic                 break_det,
`endif
  output logic                 overrun
);
  localparam int M    = OVERSAMPLE / 2;
  localparam int PH_W = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0] PH_S0   = PH_W'(M - 1);
  localparam logic [PH_W-1:0] PH_S1   = PH_W'(M);
  localparam logic [PH_W-1:0] PH_VOTE = PH_W'(M + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
  localparam logic [3:0]      BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);
  localparam bit              HAS_PAR   = (PARITY != int'(PAR_NONE));
  localparam bit              ODD_PAR   = (PARITY == int'(PAR_ODD));

  logic                 tick;
  logic                 line;
  logic                 vote;
  logic                 done;

  logic [1:0]           sync_q,     sync_d;
  rx_state_e            state_q,    state_d;
  logic [PH_W-1:0]      phase_q,    phase_d;
  logic [3:0]           bit_cnt_q,  bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 s0_q,       s0_d;
  logic                 s1_q,       s1_d;
  logic [DATA_BITS-1:0] shreg_q,    shreg_d;
  logic                 fe_q,       fe_d;
  logic                 pe_q,       pe_d;
  logic [DATA_BITS-1:0] rx_data_q,  rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q,  overrun_d;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                 par_bit_q,  par_bit_d;
  logic                 break_q,    break_d;
`endif

  uart_baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .hwclk  (hwclk),
    .resetn (resetn),
    .tick   (tick)
  );

  assign line = sync_q[1];
  assign vote = majority3(s0_q, s1_q, line);

  always_comb begin
    sync_d       = {sync_q[0], uart_rx};
    state_d      = state_q;
    phase_d      = phase_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    s0_d         = s0_q;
    s1_d         = s1_q;
    shreg_d      = shreg_q;
    fe_d         = fe_q;
    pe_d         = pe_q;
    done         = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
    par_bit_d    = par_bit_q;
    break_d      = 1'b0;
`endif

    if (tick) begin
      if (state_q != RX_IDLE) begin
        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
      end
      if (phase_q == PH_S0) s0_d = line;
      if (phase_q == PH_S1) s1_d = line;

      unique case (state_q)
        RX_IDLE: begin
          if (!line) begin
            state_d    = RX_START;
            phase_d    = '0;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
            fe_d       = 1'b0;
            pe_d       = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            par_bit_d  = 1'b0;
`endif
          end
        end
        RX_START: begin
          // A start bit that votes high was noise; drop back and hunt again.
          if (phase_q == PH_VOTE && vote) begin
            state_d = RX_IDLE;
          end else if (phase_q == PH_LAST) begin
            state_d = RX_DATA;
          end
        end
        RX_DATA: begin
          if (phase_q == PH_VOTE) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
          if (phase_q == PH_LAST) begin
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d = '0;
              state_d   = HAS_PAR ? RX_PAR : RX_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        RX_PAR: begin
          if (phase_q == PH_VOTE) begin
            pe_d = (((^shreg_q) ^ vote) != ODD_PAR);
`ifdef UART_RX_BREAK_DETECT_EN
            par_bit_d = vote;
`endif
          end
          if (phase_q == PH_LAST) state_d = RX_STOP;
        end
        RX_STOP: begin
          if (phase_q == PH_VOTE) begin
            fe_d = fe_q | ~vote;
`ifdef UART_RX_BREAK_DETECT_EN
            if (stop_cnt_q == 1'b0 && shreg_q == '0 && !par_bit_q && !vote) begin
              break_d = 1'b1;
              state_d = RX_BREAK;
              phase_d = '0;
            end else
`endif
            if (stop_cnt_q == STOP_LAST) begin
              // Finish half a bit early so a back-to-back start edge is not missed.
              done    = 1'b1;
              state_d = RX_IDLE;
            end
          end
          if (phase_q == PH_LAST && state_d == RX_STOP && stop_cnt_q != STOP_LAST) begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_BREAK_DETECT_EN
        RX_BREAK: begin
          if (!line) begin
            phase_d = '0;
          end else if (phase_q == PH_LAST) begin
            state_d = RX_IDLE;
          end
        end
`endif
        default: state_d = RX_IDLE;
      endcase
    end

    rx_data_d    = rx_data_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    rx_valid_d   = rx_valid_q && !rx_ready;
    overrun_d    = 1'b0;
    if (done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shreg_q;
        frame_err_d  = fe_d;
        parity_err_d = pe_q;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge hwclk or negedge resetn) begin
    if (!resetn) begin
      sync_q       <= 2'b11;
      state_q      <= RX_IDLE;
      phase_q      <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      s0_q         <= 1'b1;
      s1_q         <= 1'b1;
      shreg_q      <= '0;
      fe_q         <= 1'b0;
      pe_q         <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      par_bit_q    <= 1'b0;
      break_q      <= 1'b0;
`endif
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      phase_q      <= phase_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      shreg_q      <= shreg_d;
      fe_q         <= fe_d;
      pe_q         <= pe_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_BREAK_DETECT_EN
      par_bit_q    <= par_bit_d;
      break_q      <= break_d;
`endif
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
`ifdef UART_RX_BREAK_DETECT_EN
  assign break_det  = break_q;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: an 8N1 instance and an 8E1 instance,
// CLK_DIV=4, OVERSAMPLE=4 (16 clocks per bit).
module tb_uart_rx_core;
  localparam int BP = 16;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       line_n = 1'b1, line_e = 1'b1;
  logic       ready_n = 1'b1, ready_e = 1'b1;
  logic [7:0] data_n, data_e;
  logic       vld_n, vld_e, fe_n, fe_e, pe_n, pe_e, ovr_n, ovr_e;
`ifdef UART_RX_BREAK_DETECT_EN
  logic       brk_n, brk_e;
  int         brk_cnt_n = 0;
`endif

  int n_vec = 0, n_bad = 0;
  int acc_n = 0, acc_e = 0, vcyc_n = 0, ovr_cnt_n = 0;
  logic [7:0] acc_data_n = '0, acc_data_e = '0;
  logic       acc_fe_n = 1'b0, acc_pe_n = 1'b0, acc_fe_e = 1'b0, acc_pe_e = 1'b0;
  int a0, v0, o0;

  always #5 clk = ~clk;

  uart_rx_core #(.CLK_DIV(4), .OVERSAMPLE(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n (
    .hwclk(clk), .resetn(resetn), .uart_rx(line_n), .rx_data(data_n), .rx_valid(vld_n),
    .rx_ready(ready_n), .frame_err(fe_n), .parity_err(pe_n),
`ifdef UART_RX_BREAK_DETECT_EN
    .break_det(brk_n),
`endif
    .overrun(ovr_n));

  uart_rx_core #(.CLK_DIV(4), .OVERSAMPLE(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_e (
    .hwclk(clk), .resetn(resetn), .uart_rx(line_e), .rx_data(data_e), .rx_valid(vld_e),
    .rx_ready(ready_e), .frame_err(fe_e), .parity_err(pe_e),
`ifdef UART_RX_BREAK_DETECT_EN
    .break_det(brk_e),
`endif
    .overrun(ovr_e));

  always @(negedge clk) begin
    if (vld_n) vcyc_n++;
    if (ovr_n) ovr_cnt_n++;
    if (vld_n && ready_n) begin
      acc_n++; acc_data_n = data_n; acc_fe_n = fe_n; acc_pe_n = pe_n;
    end
    if (vld_e && ready_e) begin
      acc_e++; acc_data_e = data_e; acc_fe_e = fe_e; acc_pe_e = pe_e;
    end
`ifdef UART_RX_BREAK_DETECT_EN
    if (brk_n) brk_cnt_n++;
`endif
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) line_n = v;
    else            line_e = v;
  endtask

  // bits[0] is the start bit; flip inverts the first mid-bit sample window of data bits
  task automatic tx(input int which, input logic [10:0] bits, input int nb, input logic flip);
    logic v;
    for (int b = 0; b < nb; b++) begin
      for (int off = 0; off < BP; off++) begin
        v = bits[b];
        if (flip && b >= 1 && b <= 8 && off >= 4 && off < 8) v = ~v;
        set_line(which, v);
        cyc(1);
      end
    end
    set_line(which, 1'b1);
  endtask

  task automatic tx8n1(input logic [7:0] d, input logic stop_v, input logic flip);
    tx(0, {1'b1, stop_v, d, 1'b0}, 10, flip);
  endtask

  task automatic tx8e1(input logic [7:0] d, input logic par);
    tx(1, {1'b1, par, d, 1'b0}, 11, 1'b0);
  endtask

  initial begin
    cyc(3);
    chk("rst_valid", int'(vld_n), 0);
    chk("rst_data", int'(data_n), 0);
    chk("rst_fe", int'(fe_n), 0);
    chk("rst_pe", int'(pe_n), 0);
    chk("rst_ovr", int'(ovr_n), 0);
    resetn = 1'b1;
    cyc(20);

    // basic 8N1 frame with consumer always ready
    a0 = acc_n; v0 = vcyc_n;
    tx8n1(8'hA5, 1'b1, 1'b0);
    cyc(30);
    chk("a5_count", acc_n - a0, 1);
    chk("a5_data", int'(acc_data_n), 'hA5);
    chk("a5_fe", int'(acc_fe_n), 0);
    chk("a5_pe", int'(acc_pe_n), 0);
    chk("a5_vcyc", vcyc_n - v0, 1);

    // back-to-back frames while stalled: first held, second dropped
    ready_n = 1'b0;
    a0 = acc_n; o0 = ovr_cnt_n;
    tx8n1(8'h3C, 1'b1, 1'b0);
    tx8n1(8'h7E, 1'b1, 1'b0);
    cyc(30);
    chk("b2b_valid", int'(vld_n), 1);
    chk("b2b_held", int'(data_n), 'h3C);
    chk("b2b_ovr", ovr_cnt_n - o0, 1);
    chk("b2b_noacc", acc_n - a0, 0);
    ready_n = 1'b1;
    cyc(1);
    chk("b2b_acc", acc_n - a0, 1);
    chk("b2b_accdata", int'(acc_data_n), 'h3C);
    chk("b2b_clear", int'(vld_n), 0);
    cyc(10);

    // even parity: 0x07 needs parity bit 1
    a0 = acc_e;
    tx8e1(8'h07, 1'b0);
    cyc(30);
    chk("par_bad_cnt", acc_e - a0, 1);
    chk("par_bad_data", int'(acc_data_e), 'h07);
    chk("par_bad_pe", int'(acc_pe_e), 1);
    chk("par_bad_fe", int'(acc_fe_e), 0);
    tx8e1(8'h07, 1'b1);
    cyc(30);
    chk("par_ok_cnt", acc_e - a0, 2);
    chk("par_ok_pe", int'(acc_pe_e), 0);

    // stop bit forced low
    a0 = acc_n;
    tx8n1(8'h55, 1'b0, 1'b0);
    cyc(40);
    chk("fe_cnt", acc_n - a0, 1);
    chk("fe_data", int'(acc_data_n), 'h55);
    chk("fe_flag", int'(acc_fe_n), 1);

    // one-tick glitch on idle line must not produce a frame
    a0 = acc_n; v0 = vcyc_n;
    line_n = 1'b0;
    cyc(4);
    line_n = 1'b1;
    cyc(40);
    chk("glitch_acc", acc_n - a0, 0);
    chk("glitch_vcyc", vcyc_n - v0, 0);

    // one sample corrupted per data bit, vote must recover
    a0 = acc_n;
    tx8n1(8'hC3, 1'b1, 1'b1);
    cyc(30);
    chk("vote_cnt", acc_n - a0, 1);
    chk("vote_data", int'(acc_data_n), 'hC3);
    chk("vote_fe", int'(acc_fe_n), 0);

    // reset mid-frame discards held word and partial frame
    ready_n = 1'b0;
    tx8n1(8'h99, 1'b1, 1'b0);
    cyc(30);
    chk("held_99", int'(data_n), 'h99);
    line_n = 1'b0;
    cyc(40);
    resetn = 1'b0;
    cyc(2);
    chk("mid_rst_valid", int'(vld_n), 0);
    chk("mid_rst_data", int'(data_n), 0);
    line_n = 1'b1;
    cyc(2);
    resetn = 1'b1;
    cyc(30);
    chk("post_rst_valid", int'(vld_n), 0);
    ready_n = 1'b1;
    a0 = acc_n;
    tx8n1(8'h81, 1'b1, 1'b0);
    cyc(30);
    chk("rst_81_cnt", acc_n - a0, 1);
    chk("rst_81_data", int'(acc_data_n), 'h81);

`ifdef UART_RX_BREAK_DETECT_EN
    a0 = acc_n; v0 = vcyc_n; o0 = brk_cnt_n;
    line_n = 1'b0;
    cyc(20 * BP);
    line_n = 1'b1;
    cyc(40);
    chk("brk_pulse", brk_cnt_n - o0, 1);
    chk("brk_noacc", acc_n - a0, 0);
    chk("brk_novld", vcyc_n - v0, 0);
    a0 = acc_n;
    tx8n1(8'h5A, 1'b1, 1'b0);
    cyc(30);
    chk("brk_after", int'(acc_data_n), 'h5A);
`else
    a0 = acc_n;
    tx8n1(8'h00, 1'b0, 1'b0);
    cyc(40);
    chk("zero_cnt", acc_n - a0, 1);
    chk("zero_data", int'(acc_data_n), 0);
    chk("zero_fe", int'(acc_fe_n), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
